// File: rtl/irq_pkg.sv
// Purpose : shared types and constants for the interrupt controller.
// Latency : n/a (declarations only).
// Ports   : none; provides FSM state encoding, default vector base/stride, index-width helper.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

  localparam int         DEF_VEC_W    = 10;
  localparam logic [9:0] DEF_BASE_VEC = 10'h3C0;
  localparam int         VEC_STRIDE   = 4;

  // Index width for an n-entry encoder; never zero so a single source still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Purpose : CPU <-> interrupt controller signal bundle.
// Latency : n/a (wiring only).
// Ports   : master = CPU side (drives src/mask/ack/reti), slave = controller (drives irq/vector/status).
interface irq_ctrl_if #(
  parameter int N_SRC = 4,
  parameter int VEC_W = 10
);
  logic [N_SRC-1:0] src;
  logic             mask_we;
  logic [N_SRC-1:0] mask_in;
  logic             ack;
  logic             reti;
  logic             irq;
  logic [VEC_W-1:0] vector;
  logic             in_service;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;

  modport master (
    output src, mask_we, mask_in, ack, reti,
    input  irq, vector, in_service, pending, mask
  );

  modport slave (
    input  src, mask_we, mask_in, ack, reti,
    output irq, vector, in_service, pending, mask
  );
endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// Purpose : lowest-index-first priority encoder.
// Latency : combinational.
// Ports   : req (N bits) in; valid = any bit set; idx = lowest set bit index.
module prio_enc
  import irq_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Purpose : edge-latching, maskable, fixed-priority interrupt controller, one request in flight.
// Latency : src rise -> irq high after 2 edges; ack/reti take effect at the sampling edge.
// Ports   : clk, reset (async, active-high); bus (slave) carries src/mask/ack/reti in, irq/vector/status out.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int               N_SRC    = 4,
  parameter int               VEC_W    = DEF_VEC_W,
  parameter logic [VEC_W-1:0] BASE_VEC = VEC_W'(DEF_BASE_VEC)
) (
  input logic        clk,
  input logic        reset,
  irq_ctrl_if.slave  bus
);

  localparam int IW = idx_w(N_SRC);

  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] ack_clr;
  logic             win_vld;
  logic [IW-1:0]    win_idx;

  irq_state_t       state;
  logic [IW-1:0]    sel;
  logic [VEC_W-1:0] vector_q;
  logic             irq_q;
  logic             in_service_q;

  assign rise     = bus.src & ~src_q;
  assign eligible = pending_q & mask_q;

  prio_enc #(.N(N_SRC), .IW(IW)) u_prio_enc (
    .req   (eligible),
    .valid (win_vld),
    .idx   (win_idx)
  );

  // Only an ack while a request is actually presented retires the pending bit.
  always_comb begin
    ack_clr = '0;
    if (state == ST_REQ && bus.ack) ack_clr[sel] = 1'b1;
  end

  // Edge detect, pending latch and mask. OR-ing rise last makes a fresh edge win over its own ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      src_q     <= bus.src;
      pending_q <= (pending_q & ~ack_clr) | rise;
      if (bus.mask_we) mask_q <= bus.mask_in;
    end
  end

  // Request FSM. irq/in_service are flops loaded with the decode of the next state,
  // so they never carry a combinational path from the inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      sel          <= '0;
      vector_q     <= '0;
      irq_q        <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            sel      <= win_idx;
            vector_q <= BASE_VEC + VEC_W'(win_idx) * VEC_W'(VEC_STRIDE);
            state    <= ST_REQ;
            irq_q    <= 1'b1;
          end
        end
        ST_REQ: begin
          // sel/vector stay frozen here: a higher-priority arrival does not preempt.
          if (bus.ack) begin
            state        <= ST_SERVICE;
            irq_q        <= 1'b0;
            in_service_q <= 1'b1;
          end else if (!eligible[sel]) begin
            // Masked away before acceptance: withdraw but leave the edge pending.
            state <= ST_IDLE;
            irq_q <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (bus.reti) begin
            state        <= ST_IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          irq_q        <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq        = irq_q;
  assign bus.vector     = vector_q;
  assign bus.in_service = in_service_q;
  assign bus.pending    = pending_q;
  assign bus.mask       = mask_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Purpose : self-checking bench for irq_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
// Latency : n/a.
// Ports   : none.
module tb_irq_ctrl;

  localparam int N = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  irq_ctrl_if #(.N_SRC(N), .VEC_W(10)) bus ();

  irq_ctrl #(.N_SRC(N), .VEC_W(10), .BASE_VEC(10'h3C0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- behavioural model ----------------
  // m_req: source currently offered to the CPU (-1 = none); m_serving: a handler is running.
  logic [N-1:0] m_pend    = '0;
  logic [N-1:0] m_mask    = '0;
  logic [N-1:0] m_prev    = '0;
  int           m_req     = -1;
  bit           m_serving = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend = '0; m_mask = '0; m_prev = '0; m_req = -1; m_serving = 1'b0;
    end else begin
      logic [N-1:0] nxt_pend;
      nxt_pend = m_pend;
      if (m_req >= 0) begin
        if (bus.ack) begin
          nxt_pend[m_req] = 1'b0;
          m_req = -1;
          m_serving = 1'b1;
        end else if (!(m_pend[m_req] && m_mask[m_req])) begin
          m_req = -1;
        end
      end else if (m_serving) begin
        if (bus.reti) m_serving = 1'b0;
      end else begin
        for (int i = 0; i < N; i++)
          if (m_req < 0 && m_pend[i] && m_mask[i]) m_req = i;
      end
      for (int i = 0; i < N; i++)
        if (bus.src[i] && !m_prev[i]) nxt_pend[i] = 1'b1;
      m_pend = nxt_pend;
      if (bus.mask_we) m_mask = bus.mask_in;
      m_prev = bus.src;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Continuous model comparison, sampled on the falling edge.
  always @(negedge clk) begin
    chk("m_irq",        32'(bus.irq),        32'(m_req >= 0));
    chk("m_in_service", 32'(bus.in_service), 32'(m_serving));
    chk("m_pending",    32'(bus.pending),    32'(m_pend));
    chk("m_mask",       32'(bus.mask),       32'(m_mask));
    if (m_req >= 0) chk("m_vector", 32'(bus.vector), 32'h3C0 + 32'(4 * m_req));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mask(input logic [N-1:0] m);
    bus.mask_we = 1'b1; bus.mask_in = m;
    tick();
    bus.mask_we = 1'b0;
  endtask

  // Acknowledge and return from every enabled request until the controller is quiet.
  task automatic serve_all();
    int guard = 0;
    while (((bus.pending & bus.mask) != 0) || bus.irq || bus.in_service) begin
      guard++;
      if (guard > 60) begin
        n_checks++; n_fail++;
        $display("FAIL serve_timeout: controller still busy after %0d cycles", guard);
        return;
      end
      if (bus.irq) begin
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
      end else if (bus.in_service) begin
        bus.reti = 1'b1; tick(); bus.reti = 1'b0;
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    bus.src = '0; bus.mask_we = 1'b0; bus.mask_in = '0; bus.ack = 1'b0; bus.reti = 1'b0;
    tick(); tick();
    chk("rst_irq",     32'(bus.irq),        0);
    chk("rst_vector",  32'(bus.vector),     0);
    chk("rst_pending", 32'(bus.pending),    0);
    chk("rst_mask",    32'(bus.mask),       0);
    chk("rst_insvc",   32'(bus.in_service), 0);
    #2 reset = 1'b0;
    tick();

    // 1: single source, full handshake
    set_mask(4'b1111);
    chk("t1_mask", 32'(bus.mask), 32'hF);
    bus.src = 4'b0100; tick();
    chk("t1_pend", 32'(bus.pending), 32'h4);
    chk("t1_irq0", 32'(bus.irq), 0);
    bus.src = 4'b0000; tick();
    chk("t1_irq1", 32'(bus.irq), 1);
    chk("t1_vec",  32'(bus.vector), 32'h3C8);
    tick();
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    chk("t1_pend_ack", 32'(bus.pending), 0);
    chk("t1_insvc",    32'(bus.in_service), 1);
    chk("t1_irq_ack",  32'(bus.irq), 0);
    tick();
    bus.reti = 1'b1; tick(); bus.reti = 1'b0;
    chk("t1_reti", 32'(bus.in_service), 0);

    // 2: simultaneous rises, priority order, one idle cycle between services
    bus.src = 4'b1010; tick(); bus.src = 4'b0000; tick();
    chk("t2_vec1", 32'(bus.vector), 32'h3C4);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    chk("t2_pend", 32'(bus.pending), 32'h8);
    bus.reti = 1'b1; tick(); bus.reti = 1'b0;
    chk("t2_gap", 32'(bus.irq), 0);
    tick();
    chk("t2_irq2", 32'(bus.irq), 1);
    chk("t2_vec2", 32'(bus.vector), 32'h3CC);
    serve_all();

    // 3: masked source stays pending, enabling it raises irq one edge later
    set_mask(4'b0000);
    bus.src = 4'b0001; tick(); bus.src = 4'b0000;
    chk("t3_pend", 32'(bus.pending), 32'h1);
    tick();
    chk("t3_noirq", 32'(bus.irq), 0);
    set_mask(4'b0001);
    chk("t3_irq_wait", 32'(bus.irq), 0);
    tick();
    chk("t3_irq", 32'(bus.irq), 1);
    chk("t3_vec", 32'(bus.vector), 32'h3C0);
    serve_all();

    // 4: no preemption, withdraw on mask clear
    set_mask(4'b1111);
    bus.src = 4'b0100; tick(); bus.src = 4'b0000; tick();
    chk("t4_vec2", 32'(bus.vector), 32'h3C8);
    bus.src = 4'b0001; tick(); bus.src = 4'b0000;
    chk("t4_nopreempt", 32'(bus.vector), 32'h3C8);
    chk("t4_pend",      32'(bus.pending), 32'h5);
    set_mask(4'b1011);
    chk("t4_still_req", 32'(bus.irq), 1);
    tick();
    chk("t4_withdraw", 32'(bus.irq), 0);
    chk("t4_pend_kept", 32'(bus.pending), 32'h5);
    tick();
    chk("t4_vec0", 32'(bus.vector), 32'h3C0);
    serve_all();
    set_mask(4'b1111);
    serve_all();

    // 5: stray reti in REQ, re-rise at ack, stray ack in IDLE
    bus.src = 4'b0010; tick(); bus.src = 4'b0000; tick();
    bus.reti = 1'b1; tick(); bus.reti = 1'b0;
    chk("t5_stray_reti_irq", 32'(bus.irq), 1);
    chk("t5_stray_reti_vec", 32'(bus.vector), 32'h3C4);
    bus.src = 4'b0010; bus.ack = 1'b1; tick(); bus.ack = 1'b0; bus.src = 4'b0000;
    chk("t5_repend", 32'(bus.pending), 32'h2);
    chk("t5_insvc",  32'(bus.in_service), 1);
    bus.reti = 1'b1; tick(); bus.reti = 1'b0;
    serve_all();
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    chk("t5_stray_ack_irq", 32'(bus.irq), 0);
    chk("t5_stray_ack_svc", 32'(bus.in_service), 0);

    // 6: asynchronous reset mid-service
    bus.src = 4'b1000; tick(); bus.src = 4'b0000; tick();
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    chk("t6_insvc", 32'(bus.in_service), 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_irq",     32'(bus.irq), 0);
    chk("t6_insvc0",  32'(bus.in_service), 0);
    chk("t6_pending", 32'(bus.pending), 0);
    chk("t6_mask",    32'(bus.mask), 0);
    chk("t6_vector",  32'(bus.vector), 0);
    #1 reset = 1'b0;
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.src     = N'($urandom);
      bus.mask_we = ($urandom_range(0, 7) == 0);
      bus.mask_in = N'($urandom);
      bus.ack     = bus.irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      bus.reti    = bus.in_service ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      if (i % 700 == 350) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
      tick();
    end
    bus.src = '0; bus.mask_we = 1'b0; bus.ack = 1'b0; bus.reti = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller that shares the single-cycle processor between external event sources. It latches rising edges on up to N_SRC request lines, masks and prioritises them, and presents one request with its handler vector to the CPU's control path. It then holds off further requests until the CPU signals return-from-interrupt. The block sits beside `uc`/`cd` in `cpu`. The CPU drives `ack` when it diverts the PC to `vector` and `reti` when the handler returns.

## Interface
Parameters:
- N_SRC, 4, number of interrupt sources; index 0 has the highest priority
- VEC_W, 10, width of the handler vector (program-counter width)
- BASE_VEC, 10'h3C0, vector of source 0; source i uses BASE_VEC + 4*i

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- src  in  N_SRC  raw request lines, already synchronous to clk; a rising edge requests service
- mask_we  in  1  load `mask` from `mask_in` (CPU port write)
- mask_in  in  N_SRC  new enable mask; bit = 1 means the source is enabled
- ack  in  1  CPU accepted the request shown on `irq`/`vector`
- reti  in  1  CPU executed return-from-interrupt
- irq  out  1  request to CPU; reset 0
- vector  out  VEC_W  handler address, valid while `irq` = 1; reset 0
- in_service  out  1  a handler is running; reset 0
- pending  out  N_SRC  latched, not-yet-acknowledged edges; reset 0
- mask  out  N_SRC  current enable mask; reset 0 (all disabled)

## Operation
- Edge detect: register `src_q` <= `src`. Rise = `src & ~src_q`. `src_q` resets to 0.
  - A line that is already high when reset releases counts as a rise on the first edge.
- Pending latch: `pending[i]` sets on rise[i] regardless of mask. It clears only at `ack` for the selected index.
  - If rise[i] and its ack occur in the same cycle, set wins: the new edge stays pending.
- Eligible = `pending & mask`. Winner = lowest eligible index.
- FSM states IDLE, REQ, SERVICE; reset to IDLE.
  - IDLE: if eligible != 0, latch `sel` = winner and `vector` = BASE_VEC + 4*sel (truncated to VEC_W), then go to REQ.
  - REQ: `irq` = 1 and `sel`/`vector` stay frozen; a newly eligible higher-priority source does not preempt.
    - If `ack`: clear `pending[sel]` and go to SERVICE.
    - Otherwise, if `eligible[sel]` = 0 (mask cleared the bit): withdraw, go to IDLE, and keep `pending[sel]` set.
  - SERVICE: `in_service` = 1, `irq` = 0, no nesting. On `reti`, go to IDLE.
- Protocol errors: `ack` outside REQ and `reti` outside SERVICE are ignored.
- Mask write: `mask` <= `mask_in` at the edge with `mask_we`. Allowed in any state, including the same cycle as `ack` or `reti`.
- `irq` and `in_service` are decoded directly from the state register (glitch-free, no combinational path from inputs).

## Timing
- A rise sampled at edge k sets `pending` after edge k.
  - If in IDLE with the source enabled, the FSM enters REQ at edge k+1, so `irq` is high in the cycle after edge k+1. Latency from `src` rise to `irq` is 2 edges.
- `ack` sampled at edge m: `irq` falls and `in_service` rises after edge m.
- `reti` at edge n returns the FSM to IDLE. Another eligible source reaches REQ at edge n+1 at the earliest; back-to-back service has one idle cycle.
- Reset asserted mid-REQ or mid-SERVICE: all outputs return to their reset values immediately (asynchronously); the lost request is not recovered.

## Structure
- Shared package `irq_pkg`:
  - state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2)
  - default BASE_VEC
  - vector stride (4)
- Sub-module `prio_enc`: combinational lowest-index-first encoder, N_SRC-bit input, producing a `valid` flag and a `$clog2(N_SRC)`-bit index.
- Everything else (edge detect, pending, mask, FSM) lives in `irq_ctrl`. Instantiate in `cpu` beside `uc` and `cd`.

## Test plan
- Mask = 4'b1111; pulse src[2] at edge 5 → `pending` = 4'b0100 after edge 5; `irq` = 1 and `vector` = 10'h3C8 after edge 6; `ack` at edge 8 → `pending` = 0, `in_service` = 1; `reti` at edge 10 → IDLE.
- src[3] and src[1] rise together → `vector` = 10'h3C4 (src 1) first; after `reti`, the second request has `vector` = 10'h3CC.
- Mask = 4'b0000; pulse src[0] → `pending[0]` = 1, `irq` stays 0; write mask 4'b0001 → `irq` rises 1 edge later.
- In REQ for src[2], clear mask bit 2 → `irq` drops after that edge and `pending[2]` stays 1. A src[0] rise during REQ for src[2] does not change `vector`.
- src[1] rises again in the cycle it is acked → `pending[1]` stays 1 after the ack; stray `ack` in IDLE and stray `reti` in REQ leave state unchanged.
- Assert `reset` asynchronously mid-SERVICE → `irq`, `in_service`, `pending`, `mask`, `vector` = 0 immediately; state = IDLE.
